// File: rtl/serial_add_pkg.sv
// Shared types and width helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_e;

  // Width of the bit counter that indexes 0..width-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Width of a requester index, never below one bit.
  function automatic int unsigned id_w(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Request and result channels between parallel-operand clients and the sequencer.
interface serial_add_sequencer_if
  #(parameter int unsigned WIDTH = 8,
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = serial_add_pkg::id_w(N_REQ));

  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_rdy;
  logic                   res_vld;
  logic                   res_rdy;
  logic [WIDTH-1:0]       res_sum;
  logic                   res_carry;
  logic [ID_W-1:0]        res_id;

  modport master (
    output req_vld, req_a, req_b, res_rdy,
    input  req_rdy, res_vld, res_sum, res_carry, res_id
  );

  modport slave (
    input  req_vld, req_a, req_b, res_rdy,
    output req_rdy, res_vld, res_sum, res_carry, res_id
  );

endinterface

// File: rtl/serial_add_core.sv
// One-bit full adder with a registered carry; carry clears on the last bit of an operand.
module serial_add_core (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic a,
  input  logic b,
  input  logic last,
  output logic sum,
  output logic carry_out
);

  logic carry_q;
  logic carry_d;

  assign sum       = a ^ b ^ carry_q;
  assign carry_out = (a & b) | (carry_q & (a ^ b));

  // Idle cycles hold the carry; the final bit leaves it clear for the next operand.
  always_comb begin
    carry_d = carry_q;
    if (vld) begin
      carry_d = last ? 1'b0 : carry_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Round-robin sharing of one bit-serial adder between N_REQ parallel-operand requesters.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = id_w(N_REQ)
) (
  input logic                   clk,
  input logic                   rst,
  serial_add_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  serial_add_state_e state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_carry_q, res_carry_d;
  logic              res_vld_q, res_vld_d;

  logic              found_c;
  logic [ID_W-1:0]   gnt_c;
  logic [WIDTH-1:0]  sel_a_c;
  logic [WIDTH-1:0]  sel_b_c;
  logic [N_REQ-1:0]  req_rdy_c;
  logic              core_vld_c;
  logic              core_last_c;
  logic              core_sum;
  logic              core_cout;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid below it.
  always_comb begin
    found_c = 1'b0;
    gnt_c   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_c && bus.req_vld[i] && (ID_W'(i) >= ptr_q)) begin
        found_c = 1'b1;
        gnt_c   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_c && bus.req_vld[i]) begin
        found_c = 1'b1;
        gnt_c   = ID_W'(i);
      end
    end
    sel_a_c = '0;
    sel_b_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_c) begin
        sel_a_c = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_c = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  serial_add_core u_core (
    .clk       (clk),
    .rst       (rst),
    .vld       (core_vld_c),
    .a         (a_q[0]),
    .b         (b_q[0]),
    .last      (core_last_c),
    .sum       (core_sum),
    .carry_out (core_cout)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    res_id_d    = res_id_q;
    res_carry_d = res_carry_q;
    res_vld_d   = res_vld_q;
    req_rdy_c   = '0;
    core_vld_c  = 1'b0;
    core_last_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is suppressed during reset so no requester sees a phantom accept.
        if (found_c && !rst) begin
          for (int i = 0; i < N_REQ; i++) begin
            req_rdy_c[i] = (ID_W'(i) == gnt_c);
          end
          a_d      = sel_a_c;
          b_d      = sel_b_c;
          res_id_d = gnt_c;
          ptr_d    = (gnt_c == ID_W'(N_REQ - 1)) ? '0 : gnt_c + ID_W'(1);
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        core_vld_c  = 1'b1;
        core_last_c = (cnt_q == CNT_W'(WIDTH - 1));
        a_d         = a_q >> 1;
        b_d         = b_q >> 1;
        sum_d       = {core_sum, sum_q[WIDTH-1:1]};
        cnt_d       = cnt_q + CNT_W'(1);
        if (core_last_c) begin
          res_carry_d = core_cout;
          res_vld_d   = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (res_vld_q && bus.res_rdy) begin
          res_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      res_id_q    <= '0;
      res_carry_q <= 1'b0;
      res_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      res_id_q    <= res_id_d;
      res_carry_q <= res_carry_d;
      res_vld_q   <= res_vld_d;
    end
  end

  assign bus.req_rdy   = req_rdy_c;
  assign bus.res_vld   = res_vld_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Shares one bit-serial adder datapath between `N_REQ` requesters. Each requester offers a `WIDTH`-bit operand pair. The sequencer arbitrates round-robin and streams the granted pair LSB-first through a single carry-flop adder core, driving its `vld`/`last` controls. It then returns the parallel sum, the carry-out and the requester index on a valid/ready result port. The block sits between parallel-operand clients and the serial adder core; the core is built as a sub-module inside the block.

## Interface
Parameters:
- `WIDTH`, 8: operand and sum width in bits, ≥ 2.
- `N_REQ`, 2: number of requesters, ≥ 1.
- `ID_W`, `$clog2(N_REQ)` with a minimum of 1: width of the requester index.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_vld`  in  `N_REQ`: request valid, one bit per requester.
- `req_a`  in  `N_REQ*WIDTH`: operand A; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `N_REQ*WIDTH`: operand B, same packing as `req_a`.
- `req_rdy`  out  `N_REQ`: request accepted; at most one bit high at a time.
- `res_vld`  out  1: result valid.
- `res_rdy`  in  1: result consumer ready.
- `res_sum`  out  `WIDTH`: `(A+B) mod 2^WIDTH`.
- `res_carry`  out  1: carry-out of bit `WIDTH-1`.
- `res_id`  out  `ID_W`: index of the requester that owns the result.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
- **IDLE**
  - `gnt` is the first index i with `req_vld[i]=1`, searching from `ptr` upward and wrapping.
  - `req_rdy[gnt]` is combinational from `req_vld` and is high only in `IDLE`.
  - On the handshake edge: latch A, B and `gnt` into shift registers and `res_id`, set `ptr <= gnt+1` (wrapping to 0 after `N_REQ-1`), clear `bit_cnt`, go to `RUN`.
- **RUN**
  - Each cycle, drive the core with `vld=1`, `a=A[0]`, `b=B[0]`, `last=(bit_cnt==WIDTH-1)`.
  - Shift A and B right by one bit.
  - Shift the core's sum bit into the MSB of the sum register.
  - Increment `bit_cnt`.
- After `last`, capture the core carry-out into `res_carry`. The core clears its own carry in the same edge. Go to `DONE`.
- **DONE**
  - `res_vld=1`; `res_sum`, `res_carry` and `res_id` are held stable.
  - When `res_vld && res_rdy`, go to `IDLE`.
- Core vld/last rules:
  - While `vld=0`, the core ignores `last` and holds its carry.
  - The sequencer drives `vld=0` outside `RUN`.
- Requests are not queued. A requester that drops `req_vld` before it is granted is simply skipped.
- Operands are sampled only on the handshake edge. Later changes on `req_a`/`req_b` have no effect on the result.

## Timing
- Reset values:
  - state `IDLE`, `ptr=0`;
  - `req_rdy=0` while in reset;
  - `res_vld=0`, `res_sum=0`, `res_carry=0`, `res_id=0`;
  - core carry 0.
- Latency: handshake at edge E0; bits processed at edges E1..E`WIDTH`; `res_vld` is high from the cycle after E`WIDTH`.
- Throughput: one operation per `WIDTH+2` cycles when `res_rdy` is held high. No new grant is made in `DONE`, including the cycle in which the result transfers.
- Backpressure: `DONE` is held indefinitely while `res_rdy=0`. All other requesters wait.
- Simultaneous requests: exactly one grant per `IDLE` cycle. Round-robin guarantees each waiting requester is served within `N_REQ` operations.
- Reset mid-operation:
  - abort immediately and discard the partial sum;
  - core carry returns to 0, `ptr` returns to 0;
  - no `res_vld` is produced for the aborted operation.
- `N_REQ=1`: the arbiter degenerates to `req_rdy[0]=req_vld[0]` in `IDLE`.

## Structure
- Package `serial_add_pkg` holds:
  - the state typedef `serial_add_state_e` with `IDLE`, `RUN`, `DONE`;
  - a `bit_cnt` width helper function.
- Sub-module `serial_add_core`:
  - ports `clk`, `rst`, `vld`, `a`, `b`, `last`;
  - outputs `sum` (combinational sum bit) and `carry_out` (combinational `a&b | carry&(a^b)`);
  - registered carry, cleared on `rst` or on `vld&&last`.
- The top level contains the FSM, the round-robin pointer, the operand and sum shift registers, and `bit_cnt`.

## Test plan
All scenarios use `WIDTH=8`, `N_REQ=2`.
- **Single add:** req0 offers A=0x5A, B=0x33; `res_rdy=1`. Required: `res_sum=0x8D`, `res_carry=0`, `res_id=0`, `res_vld` rising 9 cycles after the handshake edge.
- **Overflow:** req1 offers A=0xFF, B=0x01. Required: `res_sum=0x00`, `res_carry=1`, `res_id=1`. The next op, 0x01+0x01, gives 0x02 with carry 0, proving the core carry was cleared.
- **Arbitration:** both requesters hold `req_vld` for 4 operations. Required: `res_id` sequence 0,1,0,1; each `req_rdy` is one-hot and only in `IDLE`.
- **Backpressure:** `res_rdy=0` for 5 cycles after `res_vld` rises. Required: `res_vld`, `res_sum` and `res_id` stay stable; `req_rdy` stays 0; the next grant comes only after the transfer.
- **Reset mid-run:** assert `rst` at bit 4 of 0xAA+0x55. Required: all outputs 0 and no result. Then 0x10+0x20 returns 0x30 with carry 0 and `res_id=0`.
- **Operand change after grant:** change `req_a` to 0x00 after the handshake of A=0x0F, B=0x01. Required: `res_sum=0x10`.
